led_panel_rx: RTL and testbench
===============================

Name: led_panel_rx

Overview:
- Panel-side receiver for the serial LED-panel interface driven by led_panel_single, for on-board loopback and simulation checking.
- Runs on the fast board clock and oversamples the slow panel signals (red/green/blue, sclk, latch, blank, aclk, arst).
- Models the panel's column shift registers and row address counter, and stores each latched row in a frame buffer that a readback port can read.
- Flags protocol errors: wrong bit count per latch, and latch asserted while the panel is not blanked.

Parameters:
COLS, 32, columns per row (shift-register length per colour)
ROWS, 16, rows per frame; row counter wraps modulo ROWS
ROW_BITS, 4, width of row index, clog2(ROWS)
COL_BITS, 5, width of column index, clog2(COLS)
CNT_BITS, 6, width of bit counter; must hold COLS+1

Ports:
clk  in  1  board clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
red_in  in  1  serial red data
green_in  in  1  serial green data
blue_in  in  1  serial blue data
sclk_in  in  1  shift clock
latch_in  in  1  row latch strobe
blank_in  in  1  output blank, high = LEDs off
aclk_in  in  1  row address advance clock
arst_in  in  1  row address reset
rd_row  in  ROW_BITS  readback row
rd_col  in  COL_BITS  readback column
rd_rgb  out  3  {r,g,b} at rd_row/rd_col, 1-cycle latency
row_valid  out  1  one-cycle pulse: row written to buffer
row_idx  out  ROW_BITS  row written, valid with row_valid
frame_done  out  1  one-cycle pulse: row ROWS-1 written
cur_row  out  ROW_BITS  current row address counter
len_err  out  1  sticky: latch with bit count != COLS
blank_err  out  1  sticky: latch rising while blank_in low
err_clr  in  1  clears len_err/blank_err

Behaviour:
- Input sync: all eight panel inputs pass through a 2-FF synchronizer of equal depth, so data stays aligned with strobes.
- Edge detect: a third register stage gives rise = s & ~s_d for sclk, latch, aclk, arst. Event latency is 3 clk from the pin.
- Reset (sync, high): shift regs, bit_cnt, cur_row, row_valid, row_idx, frame_done, len_err, blank_err, and the rd_rgb register all go to 0. The frame buffer is not reset; reading an unwritten row is don't-care.
- sclk rise: each colour shift reg becomes {sr[COLS-2:0], bit}.
  - After COLS shifts, the first-shifted bit is column COLS-1 and the last-shifted bit is column 0.
  - bit_cnt increments and saturates at COLS+1.
- latch rise:
  - Buffer row cur_row gets the 3 shift-reg values, as seen after any same-cycle shift.
  - Next cycle: row_valid=1 and row_idx=cur_row (value at latch).
  - frame_done=1 in the same cycle if that row was ROWS-1.
  - len_err is set if bit_cnt (including a same-cycle shift) != COLS.
  - blank_err is set if synced blank is 0.
  - bit_cnt goes to 0, or to 1 if a shift occurs the same cycle.
  - Shift regs are not cleared.
- Row counter:
  - arst rise sets cur_row to 0.
  - aclk rise sets cur_row to (cur_row==ROWS-1) ? 0 : cur_row+1.
  - arst and aclk in the same cycle: arst wins.
  - latch and aclk in the same cycle: the latch uses the pre-increment row.
- Error flags: err_clr clears them. Set and clear in the same cycle: set wins.
- Readback: rd_rgb is registered from buffer[rd_row][rd_col] one cycle after the address is presented.
  - A write to the same row in the same cycle returns the old data.
  - An out-of-range rd_row (>= ROWS) returns 0.
- Reset mid-row: a partial shift is discarded and bit_cnt restarts from 0. No row_valid is issued for the aborted row.

Decomposition:
- Shared package led_panel_pkg:
  - COLS/ROWS defaults and the ROW_BITS/COL_BITS derivations.
  - rgb_t (3-bit {r,g,b}).
  - Sync depth constant SYNC_STAGES=2.
- One sub-module, led_panel_rx_edge: synchronizer plus rising-edge detector, parameterised by width. It is instantiated once for the strobes and once for data/blank (data/blank use the synced value only).
- Buffer is an inferred ROWS x 3*COLS register array with no sub-module.

Test Plan:
- Reset, then one row. Shift 32 bits with red=1 only on the first bit and green=1 only on the last bit, then latch with blank=1 -> row_valid 3 clk after latch with row_idx=0; rd_row=0/rd_col=31 gives rd_rgb=100; rd_col=0 gives 010; rd_col=5 gives 000; len_err=0.
- Full frame. arst, then 16 rows each latched, each followed by aclk, with row r pattern = r in columns 0..3 -> frame_done once at row 15; cur_row wraps to 0; readback matches every row.
- Length error. 31 sclks then latch -> len_err=1. 33 sclks then latch -> still 1. err_clr -> 0. A correct row then leaves it at 0.
- Blank error. latch rise with blank_in=0 -> blank_err=1 and the row is still written. err_clr and a new latch error in the same cycle -> blank_err stays 1.
- Simultaneous events.
  - arst and aclk in the same cycle -> cur_row=0.
  - latch and aclk in the same cycle at row 7 -> row_idx=7, then cur_row=8.
  - sclk and latch in the same cycle as the 32nd bit -> no len_err.
- Reset mid-row. 10 sclks, reset, then 32 sclks and latch -> len_err=0, row 0 holds only the new data, no row_valid before the latch.

Source files
------------

// File: rtl/led_panel_pkg.sv
// Shared sizing, types and constants for the LED panel receiver.
package led_panel_pkg;

  localparam int COLS_DEF     = 32;
  localparam int ROWS_DEF     = 16;
  localparam int ROW_BITS_DEF = $clog2(ROWS_DEF);
  localparam int COL_BITS_DEF = $clog2(COLS_DEF);
  // Bit counter must reach COLS+1 so an over-length row stays distinguishable.
  localparam int CNT_BITS_DEF = $clog2(COLS_DEF + 2);

  // Synchronizer depth shared by strobes and data so both stay aligned.
  localparam int SYNC_STAGES  = 2;

  typedef logic [2:0] rgb_t;

  function automatic rgb_t pack_rgb(input logic r, input logic g, input logic b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/led_panel_rx_edge.sv
// Multi-bit synchronizer with optional rising-edge detection.
// EDGE=1: ev_o is a one-cycle rise pulse per bit; EDGE=0: ev_o is the synced level.
module led_panel_rx_edge
  import led_panel_pkg::*;
#(
  parameter int W    = 1,
  parameter bit EDGE = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] ev_o
);

  logic [W-1:0] sync_q [SYNC_STAGES];

  // Synchronizer chain; every lane passes through the same number of flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  if (EDGE) begin : g_edge
    logic [W-1:0] dly_q;

    // Extra stage holding the previous synced value for rise detection.
    always_ff @(posedge clk) begin
      if (reset) dly_q <= '0;
      else       dly_q <= sync_q[SYNC_STAGES-1];
    end

    assign ev_o = sync_q[SYNC_STAGES-1] & ~dly_q;
  end else begin : g_level
    assign ev_o = sync_q[SYNC_STAGES-1];
  end

endmodule

// File: rtl/led_panel_rx.sv
// Panel-side receiver: oversamples the serial LED panel bus, models the
// column shift registers and row counter, and captures latched rows into a
// readable frame buffer while flagging protocol errors.
module led_panel_rx
  import led_panel_pkg::*;
#(
  parameter int COLS     = COLS_DEF,
  parameter int ROWS     = ROWS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int COL_BITS = COL_BITS_DEF,
  parameter int CNT_BITS = CNT_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                red_in,
  input  logic                green_in,
  input  logic                blue_in,
  input  logic                sclk_in,
  input  logic                latch_in,
  input  logic                blank_in,
  input  logic                aclk_in,
  input  logic                arst_in,
  input  logic [ROW_BITS-1:0] rd_row,
  input  logic [COL_BITS-1:0] rd_col,
  output logic [2:0]          rd_rgb,
  output logic                row_valid,
  output logic [ROW_BITS-1:0] row_idx,
  output logic                frame_done,
  output logic [ROW_BITS-1:0] cur_row,
  output logic                len_err,
  output logic                blank_err,
  input  logic                err_clr
);

  logic [3:0] strb_ev;
  logic [3:0] dat_s;

  led_panel_rx_edge #(.W(4), .EDGE(1'b1)) u_strb (
    .clk   (clk),
    .reset (reset),
    .d_i   ({arst_in, aclk_in, latch_in, sclk_in}),
    .ev_o  (strb_ev)
  );

  led_panel_rx_edge #(.W(4), .EDGE(1'b0)) u_data (
    .clk   (clk),
    .reset (reset),
    .d_i   ({blank_in, red_in, green_in, blue_in}),
    .ev_o  (dat_s)
  );

  logic sclk_rise, latch_rise, aclk_rise, arst_rise;
  logic blank_s, red_s, green_s, blue_s;
  assign {arst_rise, aclk_rise, latch_rise, sclk_rise} = strb_ev;
  assign {blank_s, red_s, green_s, blue_s}             = dat_s;

  logic [COLS-1:0]     sr_r_q, sr_g_q, sr_b_q, sr_r_d, sr_g_d, sr_b_d;
  logic [CNT_BITS-1:0] bit_cnt_q, bit_cnt_d, cnt_shift;
  logic [ROW_BITS-1:0] cur_row_q, cur_row_d, row_idx_q;
  logic                row_valid_q, frame_done_q;
  logic                len_err_q, len_err_d, blank_err_q, blank_err_d;
  logic                row_last;
  rgb_t                rd_rgb_q;
  logic                rd_ok;

  logic [COLS-1:0] fb_r_q [ROWS];
  logic [COLS-1:0] fb_g_q [ROWS];
  logic [COLS-1:0] fb_b_q [ROWS];

  assign row_last = (cur_row_q == ROW_BITS'(ROWS - 1));

  // Next-state for shift registers, bit counter, row counter and error flags.
  always_comb begin
    sr_r_d = sr_r_q;
    sr_g_d = sr_g_q;
    sr_b_d = sr_b_q;
    if (sclk_rise) begin
      sr_r_d = {sr_r_q[COLS-2:0], red_s};
      sr_g_d = {sr_g_q[COLS-2:0], green_s};
      sr_b_d = {sr_b_q[COLS-2:0], blue_s};
    end

    cnt_shift = bit_cnt_q;
    if (sclk_rise && (bit_cnt_q != CNT_BITS'(COLS + 1))) cnt_shift = bit_cnt_q + 1'b1;

    bit_cnt_d = cnt_shift;
    if (latch_rise) bit_cnt_d = sclk_rise ? CNT_BITS'(1) : '0;

    cur_row_d = cur_row_q;
    if (arst_rise)      cur_row_d = '0;
    else if (aclk_rise) cur_row_d = row_last ? '0 : cur_row_q + 1'b1;

    // A new error in the same cycle as a clear must survive.
    len_err_d   = (latch_rise && (cnt_shift != CNT_BITS'(COLS))) | (len_err_q & ~err_clr);
    blank_err_d = (latch_rise && !blank_s) | (blank_err_q & ~err_clr);
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_r_q       <= '0;
      sr_g_q       <= '0;
      sr_b_q       <= '0;
      bit_cnt_q    <= '0;
      cur_row_q    <= '0;
      row_valid_q  <= 1'b0;
      row_idx_q    <= '0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
      blank_err_q  <= 1'b0;
    end else begin
      sr_r_q       <= sr_r_d;
      sr_g_q       <= sr_g_d;
      sr_b_q       <= sr_b_d;
      bit_cnt_q    <= bit_cnt_d;
      cur_row_q    <= cur_row_d;
      row_valid_q  <= latch_rise;
      if (latch_rise) row_idx_q <= cur_row_q;
      frame_done_q <= latch_rise && row_last;
      len_err_q    <= len_err_d;
      blank_err_q  <= blank_err_d;
    end
  end

  // Frame buffer write; captures the shift registers including a same-cycle shift.
  always_ff @(posedge clk) begin
    if (latch_rise) begin
      fb_r_q[cur_row_q] <= sr_r_d;
      fb_g_q[cur_row_q] <= sr_g_d;
      fb_b_q[cur_row_q] <= sr_b_d;
    end
  end

  if (ROWS == (1 << ROW_BITS)) begin : g_rd_full
    assign rd_ok = 1'b1;
  end else begin : g_rd_part
    assign rd_ok = ({1'b0, rd_row} < (ROW_BITS + 1)'(ROWS));
  end

  // Registered readback; a same-cycle write to the row returns the old data.
  always_ff @(posedge clk) begin
    if (reset)      rd_rgb_q <= '0;
    else if (rd_ok) rd_rgb_q <= pack_rgb(fb_r_q[rd_row][rd_col], fb_g_q[rd_row][rd_col],
                                         fb_b_q[rd_row][rd_col]);
    else            rd_rgb_q <= '0;
  end

  assign rd_rgb     = rd_rgb_q;
  assign row_valid  = row_valid_q;
  assign row_idx    = row_idx_q;
  assign frame_done = frame_done_q;
  assign cur_row    = cur_row_q;
  assign len_err    = len_err_q;
  assign blank_err  = blank_err_q;

endmodule

// File: tb/tb_led_panel_rx.sv
// Directed bench for led_panel_rx: drives the serial panel pins and checks
// row capture, row counter, error flags and readback.
module tb_led_panel_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       red_in = 1'b0, green_in = 1'b0, blue_in = 1'b0;
  logic       sclk_in = 1'b0, latch_in = 1'b0, blank_in = 1'b1;
  logic       aclk_in = 1'b0, arst_in = 1'b0, err_clr = 1'b0;
  logic [3:0] rd_row = '0;
  logic [4:0] rd_col = '0;
  logic [2:0] rd_rgb;
  logic       row_valid, frame_done, len_err, blank_err;
  logic [3:0] row_idx, cur_row;

  int n_pass = 0;
  int n_total = 0;
  logic rv_seen;

  led_panel_rx dut (
    .clk        (clk),
    .reset      (reset),
    .red_in     (red_in),
    .green_in   (green_in),
    .blue_in    (blue_in),
    .sclk_in    (sclk_in),
    .latch_in   (latch_in),
    .blank_in   (blank_in),
    .aclk_in    (aclk_in),
    .arst_in    (arst_in),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_rgb     (rd_rgb),
    .row_valid  (row_valid),
    .row_idx    (row_idx),
    .frame_done (frame_done),
    .cur_row    (cur_row),
    .len_err    (len_err),
    .blank_err  (blank_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (row_valid) rv_seen = 1'b1;
  endtask

  task automatic settle();
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic shift_bit(input logic r, input logic g, input logic b);
    red_in = r; green_in = g; blue_in = b; sclk_in = 1'b1;
    tick();
    sclk_in = 1'b0;
    tick();
  endtask

  // Column c is loaded by the (31-c)-th shift, so walk columns high to low.
  task automatic shift_row(input logic [31:0] rv, input logic [31:0] gv, input logic [31:0] bv);
    for (int c = 31; c >= 0; c--) shift_bit(rv[c], gv[c], bv[c]);
  endtask

  task automatic shift_n(input int n);
    for (int i = 0; i < n; i++) shift_bit(1'b0, 1'b0, 1'b0);
  endtask

  // Returns on the cycle where row_valid is expected high.
  task automatic do_latch();
    latch_in = 1'b1;
    tick();
    latch_in = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_aclk();
    aclk_in = 1'b1; tick(); aclk_in = 1'b0; tick();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
  endtask

  task automatic read_px(input int row, input int col, output logic [2:0] px);
    rd_row = 4'(row);
    rd_col = 5'(col);
    tick();
    px = rd_rgb;
  endtask

  logic [2:0]  px;
  logic [31:0] rv;
  logic [31:0] bv;

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_cur_row", 32'(cur_row), 32'd0);
    chk("rst_row_valid", 32'(row_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_blank_err", 32'(blank_err), 32'd0);
    chk("rst_rd_rgb", 32'(rd_rgb), 32'd0);
    reset = 1'b0;
    settle();

    // One row: red only on first shift (col 31), green only on last (col 0)
    shift_row(32'h8000_0000, 32'h0000_0001, 32'h0);
    latch_in = 1'b1; tick(); latch_in = 1'b0; tick();
    chk("t1_rv_early", 32'(row_valid), 32'd0);
    tick();
    chk("t1_row_valid", 32'(row_valid), 32'd1);
    chk("t1_row_idx", 32'(row_idx), 32'd0);
    chk("t1_frame_done", 32'(frame_done), 32'd0);
    tick();
    chk("t1_rv_pulse", 32'(row_valid), 32'd0);
    settle();
    read_px(0, 31, px); chk("t1_col31", 32'(px), 32'b100);
    read_px(0, 0, px);  chk("t1_col0", 32'(px), 32'b010);
    read_px(0, 5, px);  chk("t1_col5", 32'(px), 32'b000);
    chk("t1_len_err", 32'(len_err), 32'd0);
    chk("t1_blank_err", 32'(blank_err), 32'd0);

    // Full frame: row r holds r in red cols 0..3, blue marker in col 4
    arst_in = 1'b1; tick(); arst_in = 1'b0; settle();
    chk("t2_arst_row", 32'(cur_row), 32'd0);
    for (int r = 0; r < 16; r++) begin
      rv = 32'(r);
      shift_row(rv, 32'h0, 32'h10);
      do_latch();
      chk($sformatf("t2_rv_%0d", r), 32'(row_valid), 32'd1);
      chk($sformatf("t2_idx_%0d", r), 32'(row_idx), 32'(r));
      chk($sformatf("t2_fd_%0d", r), 32'(frame_done), (r == 15) ? 32'd1 : 32'd0);
      pulse_aclk();
      settle();
      chk($sformatf("t2_cur_%0d", r), 32'(cur_row), 32'((r + 1) % 16));
    end
    for (int r = 0; r < 16; r++) begin
      rv = 32'(r);
      for (int c = 0; c < 5; c++) begin
        read_px(r, c, px);
        chk($sformatf("t2_rd_%0d_%0d", r, c), 32'(px), {29'd0, rv[c], 1'b0, (c == 4)});
      end
    end
    chk("t2_len_err", 32'(len_err), 32'd0);

    // Length errors
    shift_n(31); do_latch(); settle();
    chk("t3_short", 32'(len_err), 32'd1);
    shift_n(33); do_latch(); settle();
    chk("t3_long", 32'(len_err), 32'd1);
    pulse_clr();
    chk("t3_clr", 32'(len_err), 32'd0);
    shift_n(32); do_latch(); settle();
    chk("t3_good", 32'(len_err), 32'd0);

    // Blank error: row still written
    blank_in = 1'b0; settle();
    shift_row(32'h0, 32'h0, 32'hFFFF_FFFF);
    do_latch();
    chk("t4_rv", 32'(row_valid), 32'd1);
    settle();
    chk("t4_blank_err", 32'(blank_err), 32'd1);
    chk("t4_len_ok", 32'(len_err), 32'd0);
    read_px(int'(cur_row), 10, px);
    chk("t4_written", 32'(px), 32'b001);
    // Clear in the same cycle as a new blank (and length) error: set wins
    latch_in = 1'b1; tick(); latch_in = 1'b0; tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    settle();
    chk("t4_set_wins", 32'(blank_err), 32'd1);
    chk("t4_len_set_wins", 32'(len_err), 32'd1);
    blank_in = 1'b1; settle();
    pulse_clr();
    chk("t4_clr_blank", 32'(blank_err), 32'd0);
    chk("t4_clr_len", 32'(len_err), 32'd0);

    // Simultaneous arst + aclk: arst wins
    pulse_aclk(); pulse_aclk(); pulse_aclk(); settle();
    arst_in = 1'b1; aclk_in = 1'b1; tick();
    arst_in = 1'b0; aclk_in = 1'b0; settle();
    chk("t5_arst_wins", 32'(cur_row), 32'd0);

    // Latch + aclk at row 7: latch sees row 7
    for (int i = 0; i < 7; i++) pulse_aclk();
    settle();
    chk("t5_row7", 32'(cur_row), 32'd7);
    shift_n(32);
    latch_in = 1'b1; aclk_in = 1'b1; tick();
    latch_in = 1'b0; aclk_in = 1'b0; tick(); tick();
    chk("t5_la_rv", 32'(row_valid), 32'd1);
    chk("t5_la_idx", 32'(row_idx), 32'd7);
    chk("t5_la_cur", 32'(cur_row), 32'd8);

    // 32nd sclk in the same cycle as latch: counts as a full row
    settle();
    shift_n(31);
    red_in = 1'b1; green_in = 1'b0; blue_in = 1'b0; sclk_in = 1'b1; latch_in = 1'b1;
    tick();
    sclk_in = 1'b0; latch_in = 1'b0; red_in = 1'b0;
    tick(); tick();
    chk("t5_sl_rv", 32'(row_valid), 32'd1);
    chk("t5_sl_idx", 32'(row_idx), 32'd8);
    settle();
    chk("t5_sl_len", 32'(len_err), 32'd0);
    read_px(8, 0, px); chk("t5_sl_col0", 32'(px), 32'b100);
    read_px(8, 1, px); chk("t5_sl_col1", 32'(px), 32'b000);

    // Reset mid-row: partial shift discarded
    for (int i = 0; i < 10; i++) shift_bit(1'b1, 1'b1, 1'b1);
    reset = 1'b1; tick(); tick();
    chk("t6_rst_cur", 32'(cur_row), 32'd0);
    reset = 1'b0; settle();
    rv_seen = 1'b0;
    shift_row(32'h0, 32'h5555_5555, 32'h0);
    settle();
    chk("t6_no_rv", 32'(rv_seen), 32'd0);
    do_latch();
    chk("t6_rv", 32'(row_valid), 32'd1);
    chk("t6_idx", 32'(row_idx), 32'd0);
    settle();
    chk("t6_len", 32'(len_err), 32'd0);
    read_px(0, 0, px);  chk("t6_col0", 32'(px), 32'b010);
    read_px(0, 1, px);  chk("t6_col1", 32'(px), 32'b000);
    read_px(0, 22, px); chk("t6_col22", 32'(px), 32'b010);
    read_px(0, 31, px); chk("t6_col31", 32'(px), 32'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
